// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file and its scrub engine.
package regfile_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 32;

  // Bit offset of lane k in a bus built from equal lanes of width w.
  function automatic int rf_slice(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_scrub_fsm.sv
// Scrub sequencer: walks every entry once after reset or on request, then idles.
// busy and clr_en are high for exactly DEPTH cycles per scrub.
module regfile_scrub_fsm
  import regfile_pkg::*;
#(
  parameter  int DEPTH  = RF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  rf_state_t state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RF_CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
    end else begin
      case (state)
        RF_CLEAR: begin
          if (clr_addr == ADDR_W'(DEPTH - 1)) begin
            state    <= RF_IDLE;
            busy     <= 1'b0;
            clr_addr <= '0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: begin
          // A request arriving mid-scrub is ignored: only IDLE looks at clr_req.
          if (clr_req) begin
            state    <= RF_CLEAR;
            busy     <= 1'b1;
            clr_addr <= '0;
          end
        end
      endcase
    end
  end

  assign clr_en = (state == RF_CLEAR);

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD combinational read ports, one write port,
// optional hardwired zero entry, optional same-cycle write bypass, scrub-on-reset.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = RF_DATA_W,
  parameter  int DEPTH    = RF_DEPTH,
  parameter  int NUM_RD   = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr_req,
  output logic                     busy
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_ok;
  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rv;

  regfile_scrub_fsm #(.DEPTH(DEPTH)) u_scrub (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  // A write is accepted only in IDLE with no competing reset or scrub request.
  assign wr_ok = we && !rst && !busy && !clr_req &&
                 !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    ra      = '0;
    rv      = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = rd_addr[rf_slice(k, ADDR_W) +: ADDR_W];
      if (((ZERO_REG != 0) && (ra == '0)) || rst || busy) begin
        rv = '0;
      end else if ((BYPASS != 0) && wr_ok && (wr_addr == ra)) begin
        rv = wr_data;
      end else begin
        rv = mem[ra];
      end
      rd_data[rf_slice(k, DATA_W) +: DATA_W] = rv;
    end
  end

endmodule
